prog_loader: RTL and testbench
==============================

# prog_loader

Sequential writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one-cycle write strobes at consecutive word-aligned byte addresses. It is the write-side counterpart of the program memory read port (word index = address[63:2]). It sits between a host or serial front end and the memory's write port. `busy` holds the CPU off while loading.

## Interface
- `DEPTH`, default 128: number of 32-bit words in the program memory.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a load; sampled only in IDLE.
- `word_count` input 8: number of words to load; sampled with `start`.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_we` output 1: write strobe, one cycle per word.
- `mem_addr` output 64: byte address, always word-aligned (bits [1:0] = 0).
- `mem_wdata` output 32: assembled instruction word.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a load completes.
- `error` output 1: one-cycle pulse on a rejected or failed load.

## Operation
- States: IDLE, RECV, WRITE, DONE (plus CHECK under the macro).
- IDLE:
  - If `start` and `word_count` > `DEPTH`, pulse `error` next cycle and stay in IDLE.
  - If `start` and `word_count` == 0, go to DONE.
  - If `start` otherwise, latch the count, clear word_idx and byte_idx, and go to RECV.
- RECV:
  - `in_ready` = 1.
  - Each accepted byte (`in_valid` & `in_ready`) is stored at bits [8*byte_idx+7 : 8*byte_idx], little-endian (first byte lands in [7:0]).
  - The fourth accepted byte moves the FSM to WRITE.
  - Cycles with `in_valid` low hold all state.
- WRITE:
  - `mem_we` = 1, `mem_addr` = word_idx << 2, `mem_wdata` = assembled word; `in_ready` = 0.
  - word_idx then increments and byte_idx clears.
  - If this was the last word, go to DONE (or CHECK when enabled); otherwise go to RECV.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` is ignored while `busy`.
- `in_ready` is decoded from the registered state only (no combinational path from `in_valid`).
- Async reset mid-load aborts immediately. Partially written memory words stay as written; there is no rollback.

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `error` 0. Internal counters reset to 0.
- IDLE to RECV: 1 cycle after `start`.
- Per word: at least 5 cycles (4 byte-accept cycles plus 1 WRITE cycle).
- Last-word `mem_we` comes 1 cycle after its fourth byte; `done` follows 1 cycle later.
- `mem_addr` and `mem_wdata` are valid whenever `mem_we` = 1 and hold their values otherwise.
- Full-memory load (`word_count` == `DEPTH`):
  - Last `mem_addr` = 4*(DEPTH-1).
  - word_idx reaches DEPTH, but `mem_addr` is never driven to 4*DEPTH while `mem_we` is high.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - A 32-bit running sum of written words is kept (modulo 2^32, cleared at `start`).
  - After the last WRITE, the FSM enters CHECK and receives 4 more bytes (same handshake, little-endian), which are not written to memory.
  - On match, go to DONE. On mismatch, pulse `error` for one cycle and return to IDLE with no `done`.
  - A `word_count` == 0 load goes straight to DONE (no checksum is received).
- `PROG_LOADER_CHECKSUM_EN` undefined:
  - No CHECK state and no sum register.
  - `error` is raised only for `word_count` > `DEPTH`.

## Test plan
- Reset with `rst_n` low, then release → all outputs 0, `in_ready` 0 until `start`.
- `start`, `word_count` = 1, bytes B3,00,20,00 with `in_valid` continuous → one `mem_we` with addr 0, data 0x002000B3; `done` 1 cycle later; 6 cycles from `start` to `done`.
- `word_count` = 3 with `in_valid` toggling every other cycle → writes at addresses 0, 4, 8 in order; data unaffected by the stalls.
- `word_count` = 200 (> 128) → `error` pulse, `busy` stays 0, no `mem_we`.
- `rst_n` asserted after word 1 of 3 is written → outputs return to reset values immediately; a new `start` writes again from address 0.
- Checksum build: words 0x1, 0x2, then checksum 0x3 → `done`. Same words with checksum 0x4 → `error`, no `done`.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of prog_loader.
// The loader is the master; the host/memory side uses the slave modport.
interface prog_loader_if;
    // A byte moves on a rising edge where in_valid and in_ready are both high;
    // in_ready depends only on loader state, never on in_valid, and the host
    // holds in_data stable while in_valid is high and in_ready is low.
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words and writes
// them to consecutive word addresses. Optional trailing checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    word_count,
    prog_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t      state;
    logic [8:0]  count;
    logic [8:0]  word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_lo;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    logic accept;
    logic last_word;

    assign accept    = bus.in_valid & bus.in_ready;
    assign last_word = (word_idx + 9'd1 == count);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            asm_lo        <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            done       <= 1'b0;
            error      <= 1'b0;
            bus.mem_we <= 1'b0;

            // The first three bytes of a word are buffered; the fourth is used
            // directly by the state that completes the word.
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    asm_lo[7:0]   <= bus.in_data;
                    2'd1:    asm_lo[15:8]  <= bus.in_data;
                    2'd2:    asm_lo[23:16] <= bus.in_data;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (int'(word_count) > DEPTH) begin
                            error <= 1'b1;
                        end else if (word_count == 8'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            count        <= {1'b0, word_count};
                            word_idx     <= '0;
                            byte_idx     <= '0;
                            state        <= S_RECV;
                            bus.in_ready <= 1'b1;
                            busy         <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                            sum          <= '0;
`endif
                        end
                    end
                end

                S_RECV: begin
                    if (accept && byte_idx == 2'd3) begin
                        state         <= S_WRITE;
                        bus.in_ready  <= 1'b0;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {53'd0, word_idx, 2'b00};
                        bus.mem_wdata <= {bus.in_data, asm_lo};
                    end
                end

                S_WRITE: begin
                    word_idx <= word_idx + 9'd1;
                    byte_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum      <= sum + bus.mem_wdata;
`endif
                    if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state        <= S_CHECK;
                        bus.in_ready <= 1'b1;
`else
                        state        <= S_DONE;
                        done         <= 1'b1;
`endif
                    end else begin
                        state        <= S_RECV;
                        bus.in_ready <= 1'b1;
                    end
                end

`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept && byte_idx == 2'd3) begin
                        bus.in_ready <= 1'b0;
                        byte_idx     <= '0;
                        if ({bus.in_data, asm_lo} == sum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: vector table of loads plus hand-written
// sequences for full-memory load, mid-load reset and start-while-busy.
module tb_prog_loader;

    localparam int DEPTH = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] word_count = 8'd0;
    logic       busy, done, error;
    logic [2:0] state_dbg;

    prog_loader_if bus();

    prog_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  wc;
        logic [95:0] bytes;
        bit          stall;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          t_done = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] last_addr = '0;
    logic [95:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard and pulse counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                we_cnt++;
                last_addr = bus.mem_addr;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: got addr %0h data %0h expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    check("write_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                t_done = cyc;
            end
            if (error) err_cnt++;
        end
    end

    task automatic clear_counts();
        we_cnt   = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic issue_start(input logic [7:0] wc);
        @(negedge clk);
        start      = 1'b1;
        word_count = wc;
        @(posedge clk);
        #1;
        t_start = cyc;
        start   = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input bit stall);
        int budget = 0;
        if (stall) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] w, input bit stall);
        for (int j = 0; j < 4; j++) feed(w[8*j +: 8], stall);
    endtask

    task automatic wait_end();
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] sum;
        clear_counts();
        sum = '0;
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.wc); i++) begin
                exp_q.push_back({64'(4 * i), v.bytes[32*i +: 32]});
                sum = sum + v.bytes[32*i +: 32];
            end
        end
        issue_start(v.wc);
        if (v.exp_err) begin
            @(negedge clk);
            #1;
            check("err_pulse", error, 1);
            check("err_busy_low", busy, 0);
            @(negedge clk);
            #1;
            check("err_one_cycle", error, 0);
            check("err_no_write", we_cnt, 0);
            check("err_no_done", done_cnt, 0);
        end else begin
            for (int i = 0; i < 4 * int'(v.wc); i++) feed(v.bytes[8*i +: 8], v.stall);
`ifdef PROG_LOADER_CHECKSUM_EN
            if (v.wc != 8'd0) feed_word(sum, v.stall);
`endif
            wait_end();
            check("done_count", done_cnt, 1);
            check("no_error", err_cnt, 0);
            check("write_count", we_cnt, v.wc);
            check("all_writes_seen", exp_q.size(), 0);
            if (v.exp_lat != 0) check("start_to_done_cycles", t_done - t_start + 1, v.exp_lat);
            @(negedge clk);
            #1;
            check("idle_after_done", {busy, done, bus.in_ready}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // wc, bytes (first byte in [7:0]), stall, exp_err, start-to-done cycles
`ifdef PROG_LOADER_CHECKSUM_EN
        vecs[0] = '{wc: 8'd1, bytes: 96'h002000B3, stall: 1'b0, exp_err: 1'b0, exp_lat: 10};
`else
        vecs[0] = '{wc: 8'd1, bytes: 96'h002000B3, stall: 1'b0, exp_err: 1'b0, exp_lat: 6};
`endif
        vecs[1] = '{wc: 8'd3, bytes: 96'h0C0B0A09_08070605_04030201, stall: 1'b1, exp_err: 1'b0, exp_lat: 0};
        vecs[2] = '{wc: 8'd200, bytes: 96'h0, stall: 1'b0, exp_err: 1'b1, exp_lat: 0};
        vecs[3] = '{wc: 8'd0, bytes: 96'h0, stall: 1'b0, exp_err: 1'b0, exp_lat: 1};
        vecs[4] = '{wc: 8'd2, bytes: 96'hDEADBEEF_12345678, stall: 1'b0, exp_err: 1'b0, exp_lat: 0};
        vecs[5] = '{wc: 8'd129, bytes: 96'h0, stall: 1'b0, exp_err: 1'b1, exp_lat: 0};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle_in_ready", bus.in_ready, 0);
        check("idle_busy", busy, 0);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Mid-load reset, with start held high while busy.
        clear_counts();
        exp_q.push_back({64'h0, 32'h11223344});
        exp_q.push_back({64'h4, 32'h55667788});
        exp_q.push_back({64'h8, 32'h99AABBCC});
        issue_start(8'd3);
        start      = 1'b1;
        word_count = 8'd200;
        feed_word(32'h11223344, 1'b0);
        begin
            int n = 0;
            while (we_cnt == 0 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("start_ignored_while_busy", err_cnt, 0);
        check("mid_load_writes", we_cnt, 1);
        start = 1'b0;
        feed(8'h88, 1'b0);
        feed(8'h77, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_mem_we", bus.mem_we, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_mem_wdata", bus.mem_wdata, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        // Full-memory load.
        clear_counts();
        begin
            logic [31:0] sum;
            sum = '0;
            for (int i = 0; i < DEPTH; i++) begin
                exp_q.push_back({64'(4 * i), 32'hA5000000 | 32'(i)});
                sum = sum + (32'hA5000000 | 32'(i));
            end
            issue_start(8'(DEPTH));
            for (int i = 0; i < DEPTH; i++) feed_word(32'hA5000000 | 32'(i), 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
            feed_word(sum, 1'b0);
`endif
        end
        wait_end();
        check("full_done", done_cnt, 1);
        check("full_no_error", err_cnt, 0);
        check("full_write_count", we_cnt, DEPTH);
        check("full_last_addr", last_addr, 64'(4 * (DEPTH - 1)));
        check("full_all_writes_seen", exp_q.size(), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good and bad trailing checksum.
        for (int k = 0; k < 2; k++) begin
            clear_counts();
            exp_q.push_back({64'h0, 32'h1});
            exp_q.push_back({64'h4, 32'h2});
            issue_start(8'd2);
            feed_word(32'h1, 1'b0);
            feed_word(32'h2, 1'b0);
            feed_word((k == 0) ? 32'h3 : 32'h4, 1'b0);
            wait_end();
            check("chk_done", done_cnt, (k == 0) ? 1 : 0);
            check("chk_error", err_cnt, (k == 0) ? 0 : 1);
            check("chk_writes", we_cnt, 2);
            @(negedge clk);
            #1;
            check("chk_idle", busy, 0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
